// File: rtl/out_bus_arbiter_pkg.sv
// ============================================================================
// out_arb_pkg : shared state encoding, default sizes, one-hot helper
// Rev 1.0
// ============================================================================
`default_nettype none

package out_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  localparam int DEF_DATA_W      = 10;
  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_HOLD_CYCLES = 16;
  localparam int MAX_REQ         = 8;

  function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
    logic [MAX_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/out_bus_arbiter_rr_pick.sv
// ============================================================================
// rr_pick : combinational round-robin picker (rotate, find-first, un-rotate)
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_pick
  import out_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = $clog2(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_in,
  input  logic [IDX_W-1:0]   ptr_in,
  output logic               found_out,
  output logic [IDX_W-1:0]   idx_out
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [IDX_W-1:0]     w_off;
  logic [IDX_W:0]       w_sum;

  // Bit 0 of the rotated vector is the requester at the pointer.
  assign w_dbl = {req_in, req_in} >> ptr_in;
  assign w_rot = w_dbl[NUM_REQ-1:0];

  always_comb begin
    found_out = 1'b0;
    w_off     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        found_out = 1'b1;
        w_off     = IDX_W'(i);
      end
    end
  end

  assign w_sum = {1'b0, ptr_in} + {1'b0, w_off};

  always_comb begin
    if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
      idx_out = IDX_W'(w_sum - (IDX_W+1)'(NUM_REQ));
    end else begin
      idx_out = w_sum[IDX_W-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/out_bus_arbiter.sv
// ============================================================================
// out_bus_arbiter : round-robin grant of a shared output bus, fixed hold window
// Rev 1.0
// ============================================================================
`default_nettype none

module out_bus_arbiter
  import out_arb_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic                      clk_in,
  input  logic                      rst_n,
  input  logic                      enable_in,
  input  logic [NUM_REQ-1:0]        req_in,
  input  logic [NUM_REQ*DATA_W-1:0] data_in,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  output logic [NUM_REQ-1:0]        grant_out,
  output logic [NUM_REQ-1:0]        done_out,
  output logic                      busy_out
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  arb_state_t         r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0]   r_gnt_idx, w_gnt_idx_nxt;
  logic [DATA_W-1:0]  r_data, w_data_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_busy, w_busy_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [NUM_REQ-1:0] r_done, w_done_nxt;

  logic               w_found;
  logic [IDX_W-1:0]   w_pick_idx;
  logic [DATA_W-1:0]  w_pick_data;
  logic [MAX_REQ-1:0] w_pick_oh8;
  logic [MAX_REQ-1:0] w_gnt_oh8;
  logic               w_grant_now;
  logic               w_hold_end;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_in    (req_in),
    .ptr_in    (r_ptr),
    .found_out (w_found),
    .idx_out   (w_pick_idx)
  );

  assign w_pick_data = data_in[int'(w_pick_idx)*DATA_W +: DATA_W];
  assign w_pick_oh8  = onehot(3'(w_pick_idx));
  assign w_gnt_oh8   = onehot(3'(r_gnt_idx));
  assign w_grant_now = (r_state == IDLE) && enable_in && w_found;
  assign w_hold_end  = (r_state == HOLD) && (r_cnt == '0);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_grant_now) w_state_nxt = HOLD;
      HOLD:    if (w_hold_end)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // done_out defaults low so it is a single-cycle pulse after each hold.
  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_ptr_nxt     = r_ptr;
    w_gnt_idx_nxt = r_gnt_idx;
    w_data_nxt    = r_data;
    w_valid_nxt   = r_valid;
    w_busy_nxt    = r_busy;
    w_grant_nxt   = r_grant;
    w_done_nxt    = '0;
    case (r_state)
      IDLE: begin
        if (w_grant_now) begin
          w_data_nxt    = w_pick_data;
          w_valid_nxt   = 1'b1;
          w_busy_nxt    = 1'b1;
          w_grant_nxt   = w_pick_oh8[NUM_REQ-1:0];
          w_gnt_idx_nxt = w_pick_idx;
          w_cnt_nxt     = CNT_W'(HOLD_CYCLES - 1);
        end
      end
      HOLD: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_valid_nxt = 1'b0;
          w_busy_nxt  = 1'b0;
          w_grant_nxt = '0;
          w_done_nxt  = w_gnt_oh8[NUM_REQ-1:0];
          if (r_gnt_idx == IDX_W'(NUM_REQ - 1)) begin
            w_ptr_nxt = '0;
          end else begin
            w_ptr_nxt = r_gnt_idx + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_ptr     <= '0;
      r_gnt_idx <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_grant   <= '0;
      r_done    <= '0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_ptr     <= w_ptr_nxt;
      r_gnt_idx <= w_gnt_idx_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_busy    <= w_busy_nxt;
      r_grant   <= w_grant_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign busy_out  = r_busy;
  assign grant_out = r_grant;
  assign done_out  = r_done;

endmodule

`default_nettype wire
